// File: rtl/UART_pkg.sv
// UART system shared definitions: data/address widths, sys_ctrl opcodes and
// the sys_ctrl FSM state encoding.
package UART_pkg;

    localparam int unsigned DATA_WIDTH    = 8;
    localparam int unsigned ADDRESS_WIDTH = 4;
    localparam int unsigned ALU_FUN_WIDTH = 4;

    // Frame opcodes (first byte of every command frame)
    localparam logic [DATA_WIDTH-1:0] CMD_RF_WR   = 8'hAA;
    localparam logic [DATA_WIDTH-1:0] CMD_RF_RD   = 8'hBB;
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OP_A,
        ST_OP_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_TX_LO,
        ST_TX_HI
    } sys_ctrl_state_e;

endpackage

// File: rtl/sys_ctrl_timer.sv
// Inter-byte timeout counter for sys_ctrl.
// Ports: clk, rst_n (async active-low); clear_i restarts the count;
// enable_i lets it run; expired_o is high for the cycle in which the count
// sits at TIMEOUT_CYCLES-1.
module sys_ctrl_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;

    // Count saturates at the limit; expired is pre-decoded one count early
    // so it lines up with cnt_q == TIMEOUT_CYCLES-1.
    always_comb begin
        cnt_d     = cnt_q;
        expired_d = 1'b0;
        if (clear_i || !enable_i) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != CNT_W'(TIMEOUT_CYCLES - 1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            expired_d = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/sys_ctrl.sv
// Command sequencer: decodes UART RX byte frames into register-file
// write/read cycles and ALU operations, and returns read data / ALU results
// to UART TX (ALU results LSB first) under a valid/busy handshake.
// Ports: CLK, RST (async active-low); RX_P_DATA/RX_D_VLD from UART RX;
// RF_Address/RF_WrEn/RF_RdEn/RF_WrData/RF_RdData/RF_RdData_valid to the
// register file; ALU_FUN/ALU_EN/ALU_OUT/ALU_OUT_VLD to the ALU;
// TX_P_DATA/TX_D_VLD/TX_BUSY to UART TX; CMD_ERR error pulse.
// Build option: define SYS_CTRL_TIMEOUT_EN to abort stalled frames after
// TIMEOUT_CYCLES cycles without a byte.
module sys_ctrl
    import UART_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [DATA_WIDTH-1:0]      RX_P_DATA,
    input  logic                       RX_D_VLD,
    output logic [ADDRESS_WIDTH-1:0]   RF_Address,
    output logic                       RF_WrEn,
    output logic                       RF_RdEn,
    output logic [DATA_WIDTH-1:0]      RF_WrData,
    input  logic [DATA_WIDTH-1:0]      RF_RdData,
    input  logic                       RF_RdData_valid,
    output logic [ALU_FUN_WIDTH-1:0]   ALU_FUN,
    output logic                       ALU_EN,
    input  logic [2*DATA_WIDTH-1:0]    ALU_OUT,
    input  logic                       ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0]      TX_P_DATA,
    output logic                       TX_D_VLD,
    input  logic                       TX_BUSY,
    output logic                       CMD_ERR
);

    localparam int unsigned RSP_W = 2 * DATA_WIDTH;

    // The timer needs at least two cycles to pre-decode its expiry.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_cfg_check
        $error("sys_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    sys_ctrl_state_e            state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]   rf_addr_q, rf_addr_d;
    logic                       rf_wr_en_q, rf_wr_en_d;
    logic                       rf_rd_en_q, rf_rd_en_d;
    logic [DATA_WIDTH-1:0]      rf_wr_data_q, rf_wr_data_d;
    logic [ALU_FUN_WIDTH-1:0]   alu_fun_q, alu_fun_d;
    logic                       alu_en_q, alu_en_d;
    logic [DATA_WIDTH-1:0]      tx_data_q, tx_data_d;
    logic                       tx_vld_q, tx_vld_d;
    logic                       cmd_err_q, cmd_err_d;
    logic [RSP_W-1:0]           rsp_q, rsp_d;
    logic                       rsp_two_q, rsp_two_d;
    logic                       tx_accept_c;
    logic                       timeout_c;

`ifdef SYS_CTRL_TIMEOUT_EN
    logic tmr_en_c;
    logic tmr_expired;

    // Timer runs only while a frame is waiting for its next byte.
    always_comb begin
        tmr_en_c = (state_q == ST_WR_ADDR) || (state_q == ST_WR_DATA) ||
                   (state_q == ST_RD_ADDR) || (state_q == ST_OP_A)    ||
                   (state_q == ST_OP_B)    || (state_q == ST_ALU_FUN);
    end

    sys_ctrl_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (CLK),
        .rst_n     (RST),
        .clear_i   (RX_D_VLD),
        .enable_i  (tmr_en_c),
        .expired_o (tmr_expired)
    );

    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout_c = tmr_expired && !RX_D_VLD;
`else
    assign timeout_c = 1'b0;
`endif

    // Byte handed to UART TX at this edge.
    assign tx_accept_c = tx_vld_q && !TX_BUSY;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        rf_wr_data_d = rf_wr_data_q;
        alu_fun_d    = alu_fun_q;
        alu_en_d     = 1'b0;
        tx_data_d    = tx_data_q;
        tx_vld_d     = tx_vld_q;
        cmd_err_d    = 1'b0;
        rsp_d        = rsp_q;
        rsp_two_d    = rsp_two_q;

        unique case (state_q)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_RF_WR:   state_d = ST_WR_ADDR;
                        CMD_RF_RD:   state_d = ST_RD_ADDR;
                        CMD_ALU_OP:  state_d = ST_OP_A;
                        CMD_ALU_NOP: state_d = ST_ALU_FUN;
                        default:     cmd_err_d = 1'b1;
                    endcase
                end
            end
            ST_WR_ADDR: begin
                if (RX_D_VLD) begin
                    rf_addr_d = RX_P_DATA[ADDRESS_WIDTH-1:0];
                    state_d   = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    rf_wr_en_d   = 1'b1;
                    rf_wr_data_d = RX_P_DATA;
                    state_d      = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    rf_addr_d  = RX_P_DATA[ADDRESS_WIDTH-1:0];
                    rf_rd_en_d = 1'b1;
                    state_d    = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (RF_RdData_valid) begin
                    rsp_d     = {DATA_WIDTH'(0), RF_RdData};
                    rsp_two_d = 1'b0;
                    state_d   = ST_TX_LO;
                end
            end
            ST_OP_A: begin
                if (RX_D_VLD) begin
                    rf_addr_d    = ADDRESS_WIDTH'(0);
                    rf_wr_en_d   = 1'b1;
                    rf_wr_data_d = RX_P_DATA;
                    state_d      = ST_OP_B;
                end
            end
            ST_OP_B: begin
                if (RX_D_VLD) begin
                    rf_addr_d    = ADDRESS_WIDTH'(1);
                    rf_wr_en_d   = 1'b1;
                    rf_wr_data_d = RX_P_DATA;
                    state_d      = ST_ALU_FUN;
                end
            end
            ST_ALU_FUN: begin
                if (RX_D_VLD) begin
                    alu_fun_d = RX_P_DATA[ALU_FUN_WIDTH-1:0];
                    alu_en_d  = 1'b1;
                    state_d   = ST_ALU_WAIT;
                end
            end
            ST_ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    rsp_d     = ALU_OUT;
                    rsp_two_d = 1'b1;
                    state_d   = ST_TX_LO;
                end
            end
            // Valid is raised one cycle after entry, so it is low for at
            // least one cycle between the low and high bytes.
            ST_TX_LO: begin
                if (tx_accept_c) begin
                    tx_vld_d = 1'b0;
                    state_d  = rsp_two_q ? ST_TX_HI : ST_IDLE;
                end else begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = rsp_q[DATA_WIDTH-1:0];
                end
            end
            ST_TX_HI: begin
                if (tx_accept_c) begin
                    tx_vld_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = rsp_q[RSP_W-1:DATA_WIDTH];
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abandon a stalled frame; operand writes already issued stand.
        if (timeout_c) begin
            state_d   = ST_IDLE;
            cmd_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            rf_addr_q    <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_wr_data_q <= '0;
            alu_fun_q    <= '0;
            alu_en_q     <= 1'b0;
            tx_data_q    <= '0;
            tx_vld_q     <= 1'b0;
            cmd_err_q    <= 1'b0;
            rsp_q        <= '0;
            rsp_two_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_wr_data_q <= rf_wr_data_d;
            alu_fun_q    <= alu_fun_d;
            alu_en_q     <= alu_en_d;
            tx_data_q    <= tx_data_d;
            tx_vld_q     <= tx_vld_d;
            cmd_err_q    <= cmd_err_d;
            rsp_q        <= rsp_d;
            rsp_two_q    <= rsp_two_d;
        end
    end

    assign RF_Address = rf_addr_q;
    assign RF_WrEn    = rf_wr_en_q;
    assign RF_RdEn    = rf_rd_en_q;
    assign RF_WrData  = rf_wr_data_q;
    assign ALU_FUN    = alu_fun_q;
    assign ALU_EN     = alu_en_q;
    assign TX_P_DATA  = tx_data_q;
    assign TX_D_VLD   = tx_vld_q;
    assign CMD_ERR    = cmd_err_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed self-checking bench for sys_ctrl: write, read with TX
// backpressure, ALU with and without operands, bad opcode, mid-frame reset
// and (when SYS_CTRL_TIMEOUT_EN is defined) the inter-byte timeout.
module tb_sys_ctrl;

    localparam int unsigned TMO = 4096;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [3:0]  RF_Address;
    logic        RF_WrEn;
    logic        RF_RdEn;
    logic [7:0]  RF_WrData;
    logic [7:0]  RF_RdData;
    logic        RF_RdData_valid;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_BUSY;
    logic        CMD_ERR;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int tx_acc = 0;
    bit both_seen = 0;

    logic [28:0] out_vec;
    assign out_vec = {RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_FUN,
                      ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR};

    sys_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .RX_P_DATA       (RX_P_DATA),
        .RX_D_VLD        (RX_D_VLD),
        .RF_Address      (RF_Address),
        .RF_WrEn         (RF_WrEn),
        .RF_RdEn         (RF_RdEn),
        .RF_WrData       (RF_WrData),
        .RF_RdData       (RF_RdData),
        .RF_RdData_valid (RF_RdData_valid),
        .ALU_FUN         (ALU_FUN),
        .ALU_EN          (ALU_EN),
        .ALU_OUT         (ALU_OUT),
        .ALU_OUT_VLD     (ALU_OUT_VLD),
        .TX_P_DATA       (TX_P_DATA),
        .TX_D_VLD        (TX_D_VLD),
        .TX_BUSY         (TX_BUSY),
        .CMD_ERR         (CMD_ERR)
    );

    always #5 CLK = ~CLK;

    // Event monitors: RF write strobes, TX acceptances, illegal strobe overlap.
    always @(posedge CLK) begin
        if (RST) begin
            if (RF_WrEn) wr_cnt++;
            if (TX_D_VLD && !TX_BUSY) tx_acc++;
            if (RF_WrEn && RF_RdEn) both_seen = 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with outputs settled.
    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    // Waits for a TX byte, holds TX_BUSY for busy_cycles while checking the
    // request stays stable, then accepts it exactly once.
    task automatic get_tx(input string tag, input int busy_cycles,
                          input logic [7:0] exp);
        int n = 0;
        int acc0;
        logic [7:0] b;
        bit stable = 1;
        TX_BUSY = (busy_cycles > 0);
        while (!TX_D_VLD && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!TX_D_VLD) begin
            check_eq({tag, "_tx_wait"}, 32'(TX_D_VLD), 32'd1);
            TX_BUSY = 1'b0;
            return;
        end
        b = TX_P_DATA;
        for (int i = 0; i < busy_cycles; i++) begin
            @(negedge CLK);
            if (!TX_D_VLD || TX_P_DATA !== b) stable = 0;
        end
        if (busy_cycles > 0) check_eq({tag, "_hold"}, 32'(stable), 32'd1);
        acc0 = tx_acc;
        TX_BUSY = 1'b0;
        @(negedge CLK);
        check_eq({tag, "_data"}, 32'(b), 32'(exp));
        check_eq({tag, "_once"}, 32'(tx_acc - acc0), 32'd1);
        check_eq({tag, "_drop"}, 32'(TX_D_VLD), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [7:0] addr,
                           input logic [7:0] rdata, input int busy);
        send_byte(8'hBB);
        send_byte(addr);
        check_eq({tag, "_rden"}, 32'({RF_RdEn, RF_WrEn}), 32'b10);
        check_eq({tag, "_addr"}, 32'(RF_Address), 32'(addr[3:0]));
        @(negedge CLK);
        check_eq({tag, "_rden_pulse"}, 32'(RF_RdEn), 32'd0);
        RF_RdData       = rdata;
        RF_RdData_valid = 1'b1;
        @(negedge CLK);
        RF_RdData_valid = 1'b0;
        get_tx(tag, busy, rdata);
        repeat (3) @(negedge CLK);
        check_eq({tag, "_single_byte"}, 32'(TX_D_VLD), 32'd0);
    endtask

    task automatic alu_result(input string tag, input logic [3:0] fun,
                              input logic [15:0] res);
        check_eq({tag, "_alu_en"}, 32'(ALU_EN), 32'd1);
        check_eq({tag, "_alu_fun"}, 32'(ALU_FUN), 32'(fun));
        @(negedge CLK);
        check_eq({tag, "_alu_en_pulse"}, 32'(ALU_EN), 32'd0);
        ALU_OUT     = res;
        ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0;
        get_tx({tag, "_lo"}, 0, res[7:0]);
        get_tx({tag, "_hi"}, 2, res[15:8]);
    endtask

    initial begin
        int w0;
        RST = 1'b0;
        RX_P_DATA = '0;
        RX_D_VLD = 1'b0;
        RF_RdData = '0;
        RF_RdData_valid = 1'b0;
        ALU_OUT = '0;
        ALU_OUT_VLD = 1'b0;
        TX_BUSY = 1'b0;

        repeat (3) @(negedge CLK);
        check_eq("reset_outputs", 32'(out_vec), 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        // Register write: AA,05,3C
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h3C);
        check_eq("wr_strobe", 32'({RF_WrEn, RF_RdEn}), 32'b10);
        check_eq("wr_addr", 32'(RF_Address), 32'h5);
        check_eq("wr_data", 32'(RF_WrData), 32'h3C);
        @(negedge CLK);
        check_eq("wr_pulse", 32'(RF_WrEn), 32'd0);
        repeat (4) @(negedge CLK);
        check_eq("wr_count", 32'(wr_cnt), 32'd1);
        check_eq("wr_no_tx", 32'(tx_acc), 32'd0);

        // Read with 10 cycles of TX backpressure
        do_read("rd02", 8'h02, 8'h81, 10);

        // ALU with operands: CC,0A,03,00 -> 0x000D
        w0 = wr_cnt;
        send_byte(8'hCC);
        send_byte(8'h0A);
        check_eq("opa_wr", 32'({RF_WrEn, RF_Address, RF_WrData}), {23'd0, 1'b1, 4'h0, 8'h0A});
        send_byte(8'h03);
        check_eq("opb_wr", 32'({RF_WrEn, RF_Address, RF_WrData}), {23'd0, 1'b1, 4'h1, 8'h03});
        send_byte(8'h00);
        alu_result("aluop", 4'h0, 16'h000D);
        check_eq("aluop_wr_count", 32'(wr_cnt - w0), 32'd2);

        // ALU without operands: DD,02 -> 0x001E
        w0 = wr_cnt;
        send_byte(8'hDD);
        send_byte(8'h02);
        alu_result("alunop", 4'h2, 16'h001E);
        check_eq("alunop_no_wr", 32'(wr_cnt - w0), 32'd0);

        // Unknown opcode, then a normal read
        send_byte(8'h55);
        check_eq("bad_op_err", 32'(CMD_ERR), 32'd1);
        @(negedge CLK);
        check_eq("bad_op_err_pulse", 32'(CMD_ERR), 32'd0);
        do_read("rd03", 8'h03, 8'h20, 0);
        check_eq("alu_fun_hold", 32'(ALU_FUN), 32'h2);

        // Reset while waiting for the write data byte
        w0 = wr_cnt;
        send_byte(8'hAA);
        send_byte(8'h07);
        RST = 1'b0;
        #1;
        check_eq("midframe_rst_outputs", 32'(out_vec), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check_eq("midframe_rst_no_wr", 32'(wr_cnt - w0), 32'd0);
        do_read("rd04", 8'h04, 8'h5A, 1);

`ifdef SYS_CTRL_TIMEOUT_EN
        begin
            int n = 0;
            send_byte(8'hAA);
            while (!CMD_ERR && n < TMO + 100) begin
                @(negedge CLK);
                n++;
            end
            check_eq("tmo_err", 32'(CMD_ERR), 32'd1);
            check_eq("tmo_cycles", 32'(n), 32'(TMO));
            @(negedge CLK);
            do_read("tmo_rd", 8'h06, 8'hC3, 0);
        end
`endif

        check_eq("wr_rd_exclusive", 32'(both_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sys_ctrl.md
# sys_ctrl

Command sequencer between the UART receiver, the register file, the ALU and the UART transmitter. It decodes byte frames arriving from UART RX into register-file write/read cycles and ALU operations. It returns read data and ALU results to UART TX under a ready/busy handshake. It is the only master of the register file's port; REG0/REG1 serve as ALU operands by convention.

## Interface
- DATA_WIDTH, 8 (from UART_pkg): byte / register width.
- ADDRESS_WIDTH, 4 (from UART_pkg): register-file address width.
- TIMEOUT_CYCLES, 4096: inter-byte timeout, used only with SYS_CTRL_TIMEOUT_EN.
- CLK  in  1  single system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- RX_P_DATA  in  DATA_WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle pulse per received byte.
- RF_Address  out  ADDRESS_WIDTH  register-file address.
- RF_WrEn / RF_RdEn  out  1  one-cycle write / read strobes; never both high.
- RF_WrData  out  DATA_WIDTH  write data.
- RF_RdData  in  DATA_WIDTH  read data.
- RF_RdData_valid  in  1  read data valid, one cycle after RF_RdEn.
- ALU_FUN  out  4  ALU function code.
- ALU_EN  out  1  one-cycle ALU start.
- ALU_OUT  in  2*DATA_WIDTH  ALU result.
- ALU_OUT_VLD  in  1  result valid pulse.
- TX_P_DATA  out  DATA_WIDTH  byte to transmit.
- TX_D_VLD  out  1  transmit request.
- TX_BUSY  in  1  transmitter busy.
- CMD_ERR  out  1  one-cycle pulse: unknown opcode or timeout abort.

## Operation
- Opcodes (first byte of a frame):
  - 0xAA write: address, then data.
  - 0xBB read: address.
  - 0xCC ALU with operands: A, then B, then FUN.
  - 0xDD ALU without operands: FUN.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI.
- IDLE, on RX_D_VLD: AA→WR_ADDR, BB→RD_ADDR, CC→OP_A, DD→ALU_FUN. Any other byte: CMD_ERR pulse, stay IDLE.
- WR_ADDR: latch RX_P_DATA[ADDRESS_WIDTH-1:0]; upper bits are ignored. Go to WR_DATA.
- WR_DATA: on the byte, drive RF_WrEn=1 with the latched address and the data for one cycle, then IDLE. No TX response.
- RD_ADDR: on the byte, drive RF_RdEn=1 for one cycle, then RD_WAIT.
- RD_WAIT: on RF_RdData_valid, capture RF_RdData as a single-byte response, then TX_LO.
- OP_A: write the byte to address 0, then OP_B.
- OP_B: write the byte to address 1, then ALU_FUN.
- ALU_FUN: on the byte, set ALU_FUN=byte[3:0] and pulse ALU_EN for one cycle, then ALU_WAIT.
- ALU_WAIT: on ALU_OUT_VLD, capture the 16-bit result, then TX_LO.
- TX_LO: present the low byte, then TX_HI (ALU responses) or IDLE (reads).
- TX_HI: present the high byte, then IDLE. ALU results are sent LSB first.
- RX bytes arriving in RD_WAIT, ALU_WAIT, TX_LO or TX_HI are dropped silently.

## Timing
- Reset: all outputs are 0 and the FSM is in IDLE. Assertion mid-frame aborts immediately, asynchronously, with no partial RF write.
- RF write is issued in the cycle after the data byte's RX_D_VLD.
- Read: RF_RdEn one cycle after the address byte; TX_D_VLD no earlier than the cycle after RF_RdData_valid.
- TX handshake:
  - TX_D_VLD and TX_P_DATA are held stable until a rising edge with TX_D_VLD=1 and TX_BUSY=0; the byte is accepted at that edge.
  - TX_D_VLD drops for at least one cycle between bytes.
- ALU_FUN holds its value until the next ALU command. ALU_EN is high for exactly one cycle.
- No transaction overlaps: one command is complete (including TX) before IDLE accepts the next opcode.

## Configuration
- SYS_CTRL_TIMEOUT_EN defined:
  - In WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B and ALU_FUN, a counter restarts on every RX_D_VLD.
  - Reaching TIMEOUT_CYCLES-1 without a byte pulses CMD_ERR and returns to IDLE, discarding the partial frame.
  - Operand writes already performed (REG0/REG1) are not undone.
- Undefined: no counter; the FSM waits indefinitely for the next byte.

## Structure
- UART_pkg adds the opcode localparams (CMD_RF_WR, CMD_RF_RD, CMD_ALU_OP, CMD_ALU_NOP) and the state enum typedef sys_ctrl_state_e.
- One sub-module: sys_ctrl_timer, the timeout counter (clear, enable, expired). It is instantiated only under SYS_CTRL_TIMEOUT_EN.

## Test plan
- AA,05,3C → one-cycle RF_WrEn with RF_Address=5, RF_WrData=0x3C; TX_D_VLD stays 0.
- BB,02 after reset → RF_RdEn with address 2; RF_RdData 0x81 is returned as TX_P_DATA=0x81, held while TX_BUSY=1 for 10 cycles, accepted once.
- CC,0A,03,00 → writes 0x0A to addr 0 and 0x03 to addr 1, ALU_EN with ALU_FUN=0; ALU_OUT=0x000D yields TX bytes 0x0D then 0x00.
- DD,02 with ALU_OUT=0x001E → no RF write, ALU_FUN=2, TX bytes 0x1E then 0x00.
- Opcode 0x55 → CMD_ERR pulse, FSM stays IDLE; a following BB,03 reads 0x20.
- RST low during WR_DATA, before the data byte → no RF_WrEn; all outputs 0. With SYS_CTRL_TIMEOUT_EN, AA then silence for TIMEOUT_CYCLES → CMD_ERR and return to IDLE.
